pack_fifo: RTL and testbench

PACK_FIFO -- requirements
Module: pack_fifo

---
 rtl/pack_fifo.sv | 117 +++++++++++
 tb/tb_pack_fifo.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pack_fifo
// Description : Narrow-in / wide-out packing FIFO. Items of DATA_WIDTH bits
//               are written one at a time; each read retires the two oldest
//               items, presented packed as one 2*DATA_WIDTH word in
//               first-word-fall-through fashion (earliest item in the low
//               half).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   ADDR_WIDTH : log2 of byte-storage depth (>= 2)
//   DATA_WIDTH : narrow write width; read width is 2*DATA_WIDTH
// Ports
//   clk     in   single clock, rising edge
//   reset   in   asynchronous active-high reset (clears pointers only)
//   wr      in   write one narrow item (ignored while full)
//   rd      in   retire one wide word (ignored while fewer than 2 items)
//   w_data  in   narrow write data
//   r_data  out  oldest two items packed, valid while ~empty
//   full    out  storage holds 2**ADDR_WIDTH items
//   empty   out  fewer than two items stored
//   level   out  number of narrow items stored
// ============================================================================
module pack_fifo #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr,
    input  logic                    rd,
    input  logic [DATA_WIDTH-1:0]   w_data,
    output logic [2*DATA_WIDTH-1:0] r_data,
    output logic                    full,
    output logic                    empty,
    output logic [ADDR_WIDTH:0]     level
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    // Pointer-width constants; ADDR_WIDTH >= 2 keeps the concatenations legal.
    localparam logic [ADDR_WIDTH:0] c_ptr_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH:0] c_ptr_two  = {{(ADDR_WIDTH-1){1'b0}}, 2'b10};
    localparam logic [ADDR_WIDTH:0] c_full_lvl = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] c_idx_one = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;

    // ------------------------------------------------------------------------
    // Status, derived purely from the registered pointers
    // ------------------------------------------------------------------------
    logic [ADDR_WIDTH:0]   w_level;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [ADDR_WIDTH-1:0] w_lo_idx;
    logic [ADDR_WIDTH-1:0] w_hi_idx;

    // Extra pointer MSB disambiguates full from empty; subtraction wraps
    // naturally modulo 2**(ADDR_WIDTH+1).
    assign w_level = r_wptr - r_rptr;
    assign w_full  = (w_level == c_full_lvl);
    assign w_empty = (w_level < c_ptr_two);

    // Both requests are qualified against pre-edge status independently, so
    // a simultaneous write and read at full completes only the read.
    assign w_wr_en = wr & ~w_full;
    assign w_rd_en = rd & ~w_empty;

    // ------------------------------------------------------------------------
    // Pointers: asynchronous reset discards all content, including an odd
    // leftover item.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wptr <= r_wptr + c_ptr_one;
            end
            if (w_rd_en) begin
                r_rptr <= r_rptr + c_ptr_two;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Storage: deliberately not reset; pointer reset alone empties the FIFO.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= w_data;
        end
    end

    // ------------------------------------------------------------------------
    // First-word-fall-through read port. The high index wraps within the
    // storage so a word may straddle the last and first entries.
    // ------------------------------------------------------------------------
    assign w_lo_idx = r_rptr[ADDR_WIDTH-1:0];
    assign w_hi_idx = w_lo_idx + c_idx_one;

    assign r_data = {r_mem[w_hi_idx], r_mem[w_lo_idx]};
    assign full   = w_full;
    assign empty  = w_empty;
    assign level  = w_level;

endmodule
`default_nettype wire

// File: tb/tb_pack_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pack_fifo
// Description : Self-checking bench for pack_fifo (ADDR_WIDTH=3,
//               DATA_WIDTH=8). Directed stimulus pushes hand-computed wide
//               words into a scoreboard queue; a monitor pops and compares
//               whenever the DUT accepts a read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pack_fifo;

    localparam int ADDR_WIDTH = 3;
    localparam int DATA_WIDTH = 8;

    logic                    clk;
    logic                    reset;
    logic                    wr;
    logic                    rd;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [2*DATA_WIDTH-1:0] r_data;
    logic                    full;
    logic                    empty;
    logic [ADDR_WIDTH:0]     level;

    int checks = 0;
    int errors = 0;
    logic [15:0] sb_q [$];

    pack_fifo #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dut (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr),
        .rd     (rd),
        .w_data (w_data),
        .r_data (r_data),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic status(input string name, input int lvl, input logic e, input logic f);
        chk({name, " level"}, 16'(level), 16'(lvl));
        chk({name, " empty"}, 16'(empty), 16'(e));
        chk({name, " full"},  16'(full),  16'(f));
    endtask

    // Drive one cycle of requests; returns at posedge+1 with inputs idle.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wr = w;
        rd = r;
        w_data = d;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
    endtask

    task automatic write_item(input logic [7:0] d);
        step(1'b1, 1'b0, d);
    endtask

    task automatic read_word(input logic [15:0] exp);
        sb_q.push_back(exp);
        step(1'b0, 1'b1, 8'h00);
    endtask

    // Monitor: an accepted read presents its word before the edge.
    always @(negedge clk) begin
        if (!reset && rd && !empty) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read", r_data);
            end else begin
                logic [15:0] exp_w;
                exp_w = sb_q.pop_front();
                if (r_data !== exp_w) begin
                    errors++;
                    $display("FAIL rd_data: got 0x%0h expected 0x%0h", r_data, exp_w);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        wr = 1'b0;
        rd = 1'b0;
        w_data = '0;
        @(posedge clk);
        #1;
        status("reset", 0, 1'b1, 1'b0);
        reset = 1'b0;

        // Basic pair
        write_item(8'h11);
        status("one_item", 1, 1'b1, 1'b0);
        write_item(8'h22);
        status("two_items", 2, 1'b0, 1'b0);
        chk("fwft_2211", r_data, 16'h2211);
        read_word(16'h2211);
        status("after_rd", 0, 1'b1, 1'b0);

        // Fill to full, overflow ignored
        for (int i = 0; i < 8; i++) write_item(8'hA0 + 8'(i));
        status("full8", 8, 1'b0, 1'b1);
        write_item(8'hFF);
        status("full_drop", 8, 1'b0, 1'b1);
        read_word(16'hA1A0);
        read_word(16'hA3A2);
        read_word(16'hA5A4);
        read_word(16'hA7A6);
        status("drained", 0, 1'b1, 1'b0);

        // Single item retained against a read
        write_item(8'h55);
        step(1'b0, 1'b1, 8'h00);
        status("single_rd", 1, 1'b1, 1'b0);
        write_item(8'h66);
        chk("fwft_6655", r_data, 16'h6655);
        read_word(16'h6655);

        // Odd occupancy through pointer wrap
        for (int i = 0; i < 7; i++) write_item(8'hC0 + 8'(i));
        read_word(16'hC1C0);
        read_word(16'hC3C2);
        read_word(16'hC5C4);
        status("odd_left", 1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) write_item(8'hB0 + 8'(i));
        status("wrap_full", 8, 1'b0, 1'b1);
        read_word(16'hB0C6);
        read_word(16'hB2B1);
        read_word(16'hB4B3);
        read_word(16'hB6B5);
        status("wrap_drained", 0, 1'b1, 1'b0);

        // Simultaneous write and read
        for (int i = 0; i < 4; i++) write_item(8'hD0 + 8'(i));
        sb_q.push_back(16'hD1D0);
        step(1'b1, 1'b1, 8'hD4);
        status("wr_rd_mid", 3, 1'b0, 1'b0);
        for (int i = 5; i < 10; i++) write_item(8'hD0 + 8'(i));
        status("refull", 8, 1'b0, 1'b1);
        sb_q.push_back(16'hD3D2);
        step(1'b1, 1'b1, 8'hEE);
        status("wr_rd_full", 6, 1'b0, 1'b0);
        read_word(16'hD5D4);
        read_word(16'hD7D6);
        read_word(16'hD9D8);
        status("wr_rd_drained", 0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle discards content
        for (int i = 0; i < 5; i++) write_item(8'h70 + 8'(i));
        status("pre_reset", 5, 1'b0, 1'b0);
        #2 reset = 1'b1;
        #1;
        status("async_reset", 0, 1'b1, 1'b0);
        reset = 1'b0;
        #2;
        write_item(8'h80);
        write_item(8'h81);
        chk("post_reset_data", r_data, 16'h8180);
        read_word(16'h8180);
        status("post_reset", 0, 1'b1, 1'b0);

        chk("sb_leftover", 16'(sb_q.size()), 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
